// File: rtl/mips_fetch_decode_execute.sv
// IF, ID (register file, control decode) and EX stages of a 5-stage MIPS pipeline, ending in EX/MEM.
// Optional macro BRANCH_FLUSH_EN: a taken branch turns the IF/ID and ID/EX contents into bubbles.
module mips_fetch_decode_execute #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          EX_MEM_PCSrc,
  input  logic [4:0]                    MEM_WB_rd,
  input  logic                          MEM_WB_regwrite,
  input  logic [31:0]                   WB_writedata,
  output logic [1:0]                    wb_ctlout,
  output logic                          branch,
  output logic                          memread,
  output logic                          memwrite,
  output logic [31:0]                   EX_MEM_NPC,
  output logic                          zero,
  output logic [31:0]                   alu_result,
  output logic [31:0]                   rdata2out,
  output logic [4:0]                    five_bit_muxout
);
  localparam int AW     = $clog2(IMEM_DEPTH);
  localparam int DATA_W = 32;

  function automatic logic signed [DATA_W-1:0] alu(input logic [1:0] op, input logic [5:0] funct,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (op)
      2'b01: r = a - b;
      2'b10: begin
        case (funct)
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h2A:   r = (a < b) ? DATA_W'(1) : '0;
          default: r = '0;
        endcase
      end
      default: r = a + b;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] pc;
  logic              flush;

  logic [DATA_W-1:0] instr_p0, npc_p0;
  logic              vld_p0;

  logic                     regdst_d, alusrc_d;
  logic [1:0]               aluop_d, wb_d;
  logic [2:0]               m_d;
  logic signed [DATA_W-1:0] rdata1_d, rdata2_d, sext_d;
  logic                     wb_en;

  logic                     regdst_p1, alusrc_p1;
  logic [1:0]               aluop_p1, wb_p1;
  logic [2:0]               m_p1;
  logic [DATA_W-1:0]        npc_p1;
  logic signed [DATA_W-1:0] rdata1_p1, rdata2_p1, sext_p1;
  logic [4:0]               rt_p1, rd_p1;

  logic signed [DATA_W-1:0] b_op, alu_d;

  logic [1:0]               wb_p2;
  logic [2:0]               m_p2;
  logic [DATA_W-1:0]        npc_p2;
  logic                     zero_p2;
  logic signed [DATA_W-1:0] alu_p2, rdata2_p2;
  logic [4:0]               dst_p2;

`ifdef BRANCH_FLUSH_EN
  assign flush = EX_MEM_PCSrc;
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  // IF -> IF/ID (_p0)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      instr_p0 <= '0;
      npc_p0   <= '0;
      vld_p0   <= 1'b0;
    end else begin
      pc <= EX_MEM_PCSrc ? npc_p2 : pc + 32'd4;
      if (flush) begin
        instr_p0 <= '0;
        npc_p0   <= '0;
        vld_p0   <= 1'b0;
      end else begin
        instr_p0 <= imem[pc[AW+1:2]];
        npc_p0   <= pc + 32'd4;
        vld_p0   <= 1'b1;
      end
    end
  end

  // ID: decode, register read with writeback bypass, sign extend
  assign wb_en  = MEM_WB_regwrite && (MEM_WB_rd != 5'd0);
  assign sext_d = {{16{instr_p0[15]}}, instr_p0[15:0]};

  always_comb begin
    regdst_d = 1'b0;
    alusrc_d = 1'b0;
    aluop_d  = 2'b00;
    wb_d     = 2'b00;
    m_d      = 3'b000;
    if (vld_p0) begin
      case (instr_p0[31:26])
        6'b000000: begin regdst_d = 1'b1; aluop_d = 2'b10; wb_d = 2'b10; end
        6'b100011: begin alusrc_d = 1'b1; wb_d = 2'b11; m_d = 3'b010; end
        6'b101011: begin alusrc_d = 1'b1; m_d = 3'b001; end
        6'b000100: begin aluop_d = 2'b01; m_d = 3'b100; end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata1_d = '0;
    rdata2_d = '0;
    if (instr_p0[25:21] != 5'd0)
      rdata1_d = (wb_en && MEM_WB_rd == instr_p0[25:21]) ? WB_writedata : regs[instr_p0[25:21]];
    if (instr_p0[20:16] != 5'd0)
      rdata2_d = (wb_en && MEM_WB_rd == instr_p0[20:16]) ? WB_writedata : regs[instr_p0[20:16]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[MEM_WB_rd] <= WB_writedata;
    end
  end

  // ID/EX (_p1)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      regdst_p1 <= 1'b0;
      alusrc_p1 <= 1'b0;
      aluop_p1  <= '0;
      wb_p1     <= '0;
      m_p1      <= '0;
      npc_p1    <= '0;
      rdata1_p1 <= '0;
      rdata2_p1 <= '0;
      sext_p1   <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
    end else begin
      regdst_p1 <= regdst_d;
      alusrc_p1 <= alusrc_d;
      aluop_p1  <= aluop_d;
      wb_p1     <= wb_d;
      m_p1      <= m_d;
      npc_p1    <= npc_p0;
      rdata1_p1 <= rdata1_d;
      rdata2_p1 <= rdata2_d;
      sext_p1   <= sext_d;
      rt_p1     <= instr_p0[20:16];
      rd_p1     <= instr_p0[15:11];
    end
  end

  // EX: funct lives in the low bits of the sign-extended immediate
  assign b_op  = alusrc_p1 ? sext_p1 : rdata2_p1;
  assign alu_d = alu(aluop_p1, sext_p1[5:0], rdata1_p1, b_op);

  // EX/MEM (_p2)
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p2     <= '0;
      m_p2      <= '0;
      npc_p2    <= '0;
      zero_p2   <= 1'b0;
      alu_p2    <= '0;
      rdata2_p2 <= '0;
      dst_p2    <= '0;
    end else begin
      wb_p2     <= wb_p1;
      m_p2      <= m_p1;
      npc_p2    <= npc_p1 + {sext_p1[29:0], 2'b00};
      zero_p2   <= (alu_d == '0);
      alu_p2    <= alu_d;
      rdata2_p2 <= rdata2_p1;
      dst_p2    <= regdst_p1 ? rd_p1 : rt_p1;
    end
  end

  assign wb_ctlout       = wb_p2;
  assign branch          = m_p2[2];
  assign memread         = m_p2[1];
  assign memwrite        = m_p2[0];
  assign EX_MEM_NPC      = npc_p2;
  assign zero            = zero_p2;
  assign alu_result      = alu_p2;
  assign rdata2out       = rdata2_p2;
  assign five_bit_muxout = dst_p2;
endmodule

// File: tb/tb_mips_fetch_decode_execute.sv
// Testbench for mips_fetch_decode_execute: directed vector table, branch sequence, random run vs. model.
module tb_mips_fetch_decode_execute;
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] npc;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } rec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic [4:0]  rd2;
    logic [31:0] d2;
    rec_t        exp;
  } vec_t;

`ifdef BRANCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk, rst, imem_we, EX_MEM_PCSrc, MEM_WB_regwrite;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata, WB_writedata;
  logic [4:0]  MEM_WB_rd;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;

  int n_checks = 0;
  int n_fail   = 0;

  mips_fetch_decode_execute #(.IMEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .EX_MEM_PCSrc(EX_MEM_PCSrc), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite),
    .WB_writedata(WB_writedata), .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread),
    .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] npc,
                              input logic z, input logic [31:0] alu, input logic [31:0] rd2,
                              input logic [4:0] dst);
    rec_t r;
    r.wb = wb; r.m = m; r.npc = npc; r.zero = z; r.alu = alu; r.rd2 = rd2; r.dst = dst;
    return r;
  endfunction

  task automatic check(input string name, input rec_t exp);
    rec_t act;
    act = {wb_ctlout, branch, memread, memwrite, EX_MEM_NPC, zero, alu_result, rdata2out, five_bit_muxout};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wb=%b m=%b npc=%h z=%b alu=%h rd2=%h dst=%0d, want wb=%b m=%b npc=%h z=%b alu=%h rd2=%h dst=%0d",
               name, act.wb, act.m, act.npc, act.zero, act.alu, act.rd2, act.dst,
               exp.wb, exp.m, exp.npc, exp.zero, exp.alu, exp.rd2, exp.dst);
    end
  endtask

  // Behavioural reference: whole-instruction effect computed from the instruction set rules.
  function automatic rec_t predict(input logic [31:0] ins, input logic [31:0] npc,
                                   input logic [31:0] a, input logic [31:0] b, input logic vld);
    rec_t r;
    logic [31:0] sx;
    logic [5:0] op;
    op = vld ? ins[31:26] : 6'h3F;
    sx = {{16{ins[15]}}, ins[15:0]};
    r = '0;
    r.npc = npc + (sx << 2);
    r.rd2 = b;
    r.dst = ins[20:16];
    case (op)
      6'h00: begin
        r.wb = 2'b10;
        r.dst = ins[15:11];
        case (ins[5:0])
          6'h20:   r.alu = a + b;
          6'h22:   r.alu = a - b;
          6'h24:   r.alu = a & b;
          6'h25:   r.alu = a | b;
          6'h2A:   r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: r.alu = 32'd0;
        endcase
      end
      6'h23:   begin r.wb = 2'b11; r.m = 3'b010; r.alu = a + sx; end
      6'h2B:   begin r.m = 3'b001; r.alu = a + sx; end
      6'h04:   begin r.m = 3'b100; r.alu = a - b; end
      default: r.alu = a + b;
    endcase
    r.zero = (r.alu == 32'd0);
    return r;
  endfunction

  logic [31:0] m_pc, m_id_instr, m_id_npc;
  logic        m_id_vld;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [64];
  rec_t        m_ex, m_out;

  function automatic logic [31:0] rdreg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (MEM_WB_regwrite && MEM_WB_rd == r) return WB_writedata;
    return m_regs[r];
  endfunction

  // Advance the model across the coming rising edge using the inputs currently driven.
  task automatic model_step();
    rec_t id_rec;
    logic [31:0] nxt;
    logic fl;
    id_rec = predict(m_id_instr, m_id_npc, rdreg(m_id_instr[25:21]), rdreg(m_id_instr[20:16]), m_id_vld);
    if (rst) begin
      m_pc = 0; m_id_instr = 0; m_id_npc = 0; m_id_vld = 1'b0;
      m_ex = predict(0, 0, 0, 0, 1'b0);
      m_out = '0;
      for (int k = 0; k < 32; k++) m_regs[k] = 0;
    end else begin
      fl  = EX_MEM_PCSrc && FLUSH;
      nxt = EX_MEM_PCSrc ? m_out.npc : m_pc + 4;
      m_out = m_ex;
      m_ex  = fl ? predict(0, 0, 0, 0, 1'b0) : id_rec;
      if (fl) begin
        m_id_instr = 0; m_id_npc = 0; m_id_vld = 1'b0;
      end else begin
        m_id_instr = m_imem[m_pc[7:2]]; m_id_npc = m_pc + 4; m_id_vld = 1'b1;
      end
      if (MEM_WB_regwrite && MEM_WB_rd != 5'd0) m_regs[MEM_WB_rd] = WB_writedata;
      m_pc = nxt;
    end
    if (imem_we) m_imem[imem_addr] = imem_wdata;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic [5:0] fn [5];
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h2A;
    rs = 5'($urandom_range(7)); rt = 5'($urandom_range(7)); rd = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(9))
      0, 1, 2, 3, 4: return {6'h00, rs, rt, rd, 5'd0, fn[$urandom_range(4)]};
      5:             return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
      6:             return {6'h23, rs, rt, imm};
      7:             return {6'h2B, rs, rt, imm};
      8:             return {6'h04, rs, rt, imm};
      default:       return {6'($urandom), rs, rt, imm};
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    rst = 1'b1; imem_we = 1'b1; imem_addr = 6'd0; imem_wdata = v.instr;
    @(negedge clk);
    imem_we = 1'b0;
    check($sformatf("reset_v%0d", idx), '0);
    rst = 1'b0;
    MEM_WB_regwrite = 1'b1; MEM_WB_rd = v.rd1; WB_writedata = v.d1;
    @(negedge clk);
    MEM_WB_rd = v.rd2; WB_writedata = v.d2;
    @(negedge clk);
    MEM_WB_regwrite = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d", idx), v.exp);
  endtask

  vec_t vecs [16];
  rec_t exp_br [5];
  logic [31:0] prog [5];
  rec_t zrec;

  initial begin
    rst = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0; EX_MEM_PCSrc = 1'b0;
    MEM_WB_rd = '0; MEM_WB_regwrite = 1'b0; WB_writedata = '0;
    zrec = mk(2'b00, 3'b000, 32'h0, 1'b1, 32'h0, 32'h0, 5'd0);

    vecs[0]  = '{32'h00221820, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'h6084, 1'b0, 32'd12, 32'd7, 5'd3)};
    vecs[1]  = '{32'h8C240008, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b11, 3'b010, 32'h24, 1'b0, 32'd13, 32'd0, 5'd4)};
    vecs[2]  = '{32'h00223022, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'hC08C, 1'b0, 32'hFFFFFFFE, 32'd7, 5'd6)};
    vecs[3]  = '{32'h0022282A, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'hA0AC, 1'b0, 32'd1, 32'd7, 5'd5)};
    vecs[4]  = '{32'h00213022, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'hC08C, 1'b1, 32'd0, 32'd5, 5'd6)};
    vecs[5]  = '{32'h10210003, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b00, 3'b100, 32'h10, 1'b1, 32'd0, 32'd5, 5'd1)};
    vecs[6]  = '{32'hAC220010, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b00, 3'b001, 32'h44, 1'b0, 32'd21, 32'd7, 5'd2)};
    vecs[7]  = '{32'h00221824, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'h6094, 1'b0, 32'd5, 32'd7, 5'd3)};
    vecs[8]  = '{32'h00221825, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'h6098, 1'b0, 32'd7, 32'd7, 5'd3)};
    vecs[9]  = '{32'h00221821, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'h6088, 1'b1, 32'd0, 32'd7, 5'd3)};
    vecs[10] = '{32'h0022282A, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd7, mk(2'b10, 3'b000, 32'hA0AC, 1'b0, 32'd1, 32'd7, 5'd5)};
    vecs[11] = '{32'h0022282A, 5'd1, 32'd7, 5'd2, 32'hFFFFFFFF, mk(2'b10, 3'b000, 32'hA0AC, 1'b1, 32'd0, 32'hFFFFFFFF, 5'd5)};
    vecs[12] = '{32'h3C221234, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b00, 3'b000, 32'h48D4, 1'b0, 32'd12, 32'd7, 5'd2)};
    vecs[13] = '{32'h8C24FFFC, 5'd1, 32'd5, 5'd2, 32'd7, mk(2'b11, 3'b010, 32'hFFFFFFF4, 1'b0, 32'd1, 32'd0, 5'd4)};
    vecs[14] = '{32'h00221820, 5'd1, 32'h7FFFFFFF, 5'd2, 32'd1, mk(2'b10, 3'b000, 32'h6084, 1'b0, 32'h80000000, 32'd1, 5'd3)};
    vecs[15] = '{32'h00221820, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, mk(2'b10, 3'b000, 32'h6084, 1'b1, 32'd0, 32'd1, 5'd3)};

    @(negedge clk);
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Writeback bypass: the second write to reg1 lands on the edge the add is read in ID.
    run_vec('{32'h00201820, 5'd1, 32'h1111, 5'd1, 32'hABCD,
              mk(2'b10, 3'b000, 32'h6084, 1'b0, 32'hABCD, 32'd0, 5'd3)}, 16);
    // Writes to reg0 neither land nor bypass.
    run_vec('{32'h00001820, 5'd0, 32'd9, 5'd0, 32'd9,
              mk(2'b10, 3'b000, 32'h6084, 1'b1, 32'd0, 32'd0, 5'd3)}, 17);

    // Taken branch: beq at word 0, target word 4, wrong-path words 1..3.
    prog[0] = 32'h10210003; prog[1] = 32'h00221820; prog[2] = 32'h00223022;
    prog[3] = 32'h0022282A; prog[4] = 32'h00221825;
    exp_br[0] = mk(2'b00, 3'b100, 32'h10, 1'b1, 32'd0, 32'd5, 5'd1);
    exp_br[1] = mk(2'b10, 3'b000, 32'h6088, 1'b0, 32'd12, 32'd7, 5'd3);
    exp_br[2] = FLUSH ? zrec : mk(2'b10, 3'b000, 32'hC094, 1'b0, 32'hFFFFFFFE, 32'd7, 5'd6);
    exp_br[3] = FLUSH ? zrec : mk(2'b10, 3'b000, 32'hA0B8, 1'b0, 32'd1, 32'd7, 5'd5);
    exp_br[4] = mk(2'b10, 3'b000, 32'h60A8, 1'b0, 32'd7, 32'd7, 5'd3);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      imem_we = 1'b1; imem_addr = 6'(k); imem_wdata = prog[k];
      @(negedge clk);
    end
    imem_we = 1'b0; rst = 1'b0;
    MEM_WB_regwrite = 1'b1; MEM_WB_rd = 5'd1; WB_writedata = 32'd5;
    @(negedge clk);
    MEM_WB_rd = 5'd2; WB_writedata = 32'd7;
    @(negedge clk);
    MEM_WB_regwrite = 1'b0;
    @(negedge clk);
    check("br_beq", exp_br[0]);
    EX_MEM_PCSrc = 1'b1;
    @(negedge clk);
    EX_MEM_PCSrc = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("br_slot%0d", k), exp_br[k]);
      if (k < 4) @(negedge clk);
    end

    // Random run against the behavioural model; imem loaded under reset first.
    rst = 1'b1;
    for (int k = 0; k < 64; k++) begin
      imem_we = 1'b1; imem_addr = 6'(k); imem_wdata = rand_instr();
      m_imem[k] = imem_wdata;
      @(negedge clk);
    end
    imem_we = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst = (i == 0) || ($urandom_range(49) == 0) || (i % 97 == 50);
      EX_MEM_PCSrc = ($urandom_range(7) == 0) || (i % 97 == 50);
      MEM_WB_regwrite = 1'($urandom_range(1));
      MEM_WB_rd = 5'($urandom_range(7));
      WB_writedata = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
      imem_we = ($urandom_range(15) == 0);
      imem_addr = 6'($urandom);
      imem_wdata = rand_instr();
      model_step();
      @(negedge clk);
      check($sformatf("rand%0d", i), m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
